// File: rtl/relu_backprop.sv
// Streaming ReLU with a per-sample activation mask: forward phase emits ReLU(x) and
// records x>0; backward phase gates gradients with that mask. Option: RELU_LEAKY_EN (slope 1/8).
module relu_backprop #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 20,
  parameter int CNT_W  = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fwd_valid,
  input  logic signed [DATA_W-1:0] fwd_data,
  output logic                     fwd_ready,
  output logic signed [DATA_W-1:0] fwd_out,
  output logic                     fwd_out_valid,
  input  logic                     bwd_valid,
  input  logic signed [DATA_W-1:0] bwd_grad,
  output logic                     bwd_ready,
  output logic signed [DATA_W-1:0] grad_out,
  output logic                     grad_out_valid,
  output logic                     done
);

  typedef enum logic {S_FWD = 1'b0, S_BWD = 1'b1} state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [CNT_W-1:0]           r_cnt;
  logic [CNT_W-1:0]           w_cnt_next;
  logic [DEPTH-1:0]           r_mask;
  logic signed [DATA_W-1:0]   r_fwd_out;
  logic                       r_fwd_out_valid;
  logic signed [DATA_W-1:0]   r_grad_out;
  logic                       r_grad_out_valid;
  logic                       r_done;

  logic                       w_fwd_ready;
  logic                       w_bwd_ready;
  logic                       w_fwd_acc;
  logic                       w_bwd_acc;
  logic                       w_last;
  logic                       w_pos;
  logic                       w_mask_bit;
  logic signed [DATA_W-1:0]   w_relu;
  logic signed [DATA_W-1:0]   w_grad_gated;

  assign w_fwd_acc  = fwd_valid && w_fwd_ready;
  assign w_bwd_acc  = bwd_valid && w_bwd_ready;
  assign w_last     = (r_cnt == CNT_W'(DEPTH - 1));
  // Strictly positive: sign bit clear and not zero.
  assign w_pos      = !fwd_data[DATA_W-1] && (|fwd_data);
  assign w_mask_bit = r_mask[r_cnt];

`ifdef RELU_LEAKY_EN
  assign w_relu       = w_pos ? fwd_data : (fwd_data >>> 3);
  assign w_grad_gated = w_mask_bit ? bwd_grad : (bwd_grad >>> 3);
`else
  assign w_relu       = w_pos ? fwd_data : '0;
  assign w_grad_gated = w_mask_bit ? bwd_grad : '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FWD;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_fwd_ready  = 1'b0;
    w_bwd_ready  = 1'b0;
    case (r_state)
      S_FWD: begin
        w_fwd_ready = 1'b1;
        if (w_fwd_acc) begin
          w_cnt_next = w_last ? '0 : r_cnt + 1'b1;
          if (w_last) w_state_next = S_BWD;
        end
      end
      S_BWD: begin
        w_bwd_ready = 1'b1;
        if (w_bwd_acc) begin
          w_cnt_next = w_last ? '0 : r_cnt + 1'b1;
          if (w_last) w_state_next = S_FWD;
        end
      end
      default: w_state_next = S_FWD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask           <= '0;
      r_fwd_out        <= '0;
      r_fwd_out_valid  <= 1'b0;
      r_grad_out       <= '0;
      r_grad_out_valid <= 1'b0;
      r_done           <= 1'b0;
    end else begin
      r_fwd_out_valid  <= w_fwd_acc;
      r_grad_out_valid <= w_bwd_acc;
      r_done           <= w_bwd_acc && w_last;
      if (w_fwd_acc) begin
        r_fwd_out     <= w_relu;
        r_mask[r_cnt] <= w_pos;
      end
      if (w_bwd_acc) begin
        r_grad_out <= w_grad_gated;
        // Mask is consumed once per batch; clear it as the last gradient leaves.
        if (w_last) r_mask <= '0;
      end
    end
  end

  assign fwd_ready      = w_fwd_ready;
  assign bwd_ready      = w_bwd_ready;
  assign fwd_out        = r_fwd_out;
  assign fwd_out_valid  = r_fwd_out_valid;
  assign grad_out       = r_grad_out;
  assign grad_out_valid = r_grad_out_valid;
  assign done           = r_done;

endmodule
